// File: rtl/operand_entry_ctrl.sv
// Operand entry sequencer: collects BCD digits and a sign from key strobes,
// converts them to a signed binary value and offers it on a valid/ready handshake.
module operand_entry_ctrl #(
    parameter int NDIGITS      = 3,
    parameter int OUT_W        = 11,
    parameter int NUM_OPERANDS = 2,
    localparam int IW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [3:0]             digit_in,
    input  logic                   digit_stb,
    input  logic                   sign_stb,
    input  logic                   enter_stb,
    input  logic                   clear_stb,
    input  logic                   out_ready,
    output logic                   op_valid,
    output logic [OUT_W-1:0]       op_value,
    output logic [IW-1:0]          op_index,
    output logic                   busy,
    output logic                   err_digit,
    output logic [4*NDIGITS-1:0]   disp_digits,
    output logic                   disp_sign
);

    localparam int ACC_W = OUT_W - 1;
    localparam int KW    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int CW    = $clog2(NDIGITS + 1);

    typedef enum logic [1:0] {ENTRY, CONV, SIGN, VALID} state_t;

    state_t           state_reg;
    logic [3:0]       digits_reg [NDIGITS];
    logic             sign_reg;
    logic [CW-1:0]    count_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [KW-1:0]    k_reg;
    logic [3:0]       cur_digit;
    logic [ACC_W-1:0] acc_next;
    logic             digit_ok;

    // Conversion walks the digits from the most significant one down.
    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (k_reg == KW'(i)) cur_digit = digits_reg[NDIGITS-1-i];
        end
    end

    assign acc_next = acc_reg * ACC_W'(10) + ACC_W'(cur_digit);
    assign digit_ok = (digit_in <= 4'd9) && (count_reg < CW'(NDIGITS));
    assign busy     = (state_reg != ENTRY);
    assign disp_sign = sign_reg;

    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_disp
            assign disp_digits[gi*4 +: 4] = digits_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ENTRY;
            for (int i = 0; i < NDIGITS; i++) digits_reg[i] <= 4'd0;
            sign_reg  <= 1'b0;
            count_reg <= '0;
            acc_reg   <= '0;
            k_reg     <= '0;
            op_value  <= '0;
            op_valid  <= 1'b0;
            op_index  <= '0;
            err_digit <= 1'b0;
        end else begin
            err_digit <= 1'b0;
            if (clear_stb) begin
                for (int i = 0; i < NDIGITS; i++) digits_reg[i] <= 4'd0;
                sign_reg  <= 1'b0;
                count_reg <= '0;
                acc_reg   <= '0;
                op_valid  <= 1'b0;
                state_reg <= ENTRY;
            end else begin
                case (state_reg)
                    ENTRY: begin
                        if (enter_stb) begin
                            acc_reg   <= '0;
                            k_reg     <= '0;
                            state_reg <= CONV;
                        end else begin
                            if (sign_stb) sign_reg <= ~sign_reg;
                            if (digit_stb) begin
                                if (digit_ok) begin
                                    for (int i = NDIGITS-1; i > 0; i--) digits_reg[i] <= digits_reg[i-1];
                                    digits_reg[0] <= digit_in;
                                    count_reg     <= count_reg + CW'(1);
                                end else begin
                                    err_digit <= 1'b1;
                                end
                            end
                        end
                    end
                    CONV: begin
                        acc_reg <= acc_next;
                        k_reg   <= k_reg + KW'(1);
                        if (k_reg == KW'(NDIGITS-1)) state_reg <= SIGN;
                    end
                    SIGN: begin
                        // Negating zero yields zero, so no special case for "-0".
                        op_value  <= sign_reg ? (OUT_W'(0) - {1'b0, acc_reg}) : {1'b0, acc_reg};
                        op_valid  <= 1'b1;
                        state_reg <= VALID;
                    end
                    VALID: begin
                        if (out_ready) begin
                            op_valid <= 1'b0;
                            for (int i = 0; i < NDIGITS; i++) digits_reg[i] <= 4'd0;
                            sign_reg  <= 1'b0;
                            count_reg <= '0;
                            op_index  <= (op_index == IW'(NUM_OPERANDS-1)) ? '0 : op_index + IW'(1);
                            state_reg <= ENTRY;
                        end
                    end
                    default: state_reg <= ENTRY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Directed bench for operand_entry_ctrl: entry, conversion, handshake, clear and reset.
module tb_operand_entry_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  digit_in;
    logic        digit_stb, sign_stb, enter_stb, clear_stb, out_ready;
    logic        op_valid;
    logic [10:0] op_value;
    logic [0:0]  op_index;
    logic        busy, err_digit, disp_sign;
    logic [11:0] disp_digits;

    int checks = 0;
    int errors = 0;

    operand_entry_ctrl #(.NDIGITS(3), .OUT_W(11), .NUM_OPERANDS(2)) dut (
        .clk(clk), .reset_n(reset_n), .digit_in(digit_in), .digit_stb(digit_stb),
        .sign_stb(sign_stb), .enter_stb(enter_stb), .clear_stb(clear_stb),
        .out_ready(out_ready), .op_valid(op_valid), .op_value(op_value),
        .op_index(op_index), .busy(busy), .err_digit(err_digit),
        .disp_digits(disp_digits), .disp_sign(disp_sign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] d, input logic dg, input logic sg,
                          input logic en, input logic cl);
        digit_in = d; digit_stb = dg; sign_stb = sg; enter_stb = en; clear_stb = cl;
        step();
        digit_stb = 0; sign_stb = 0; enter_stb = 0; clear_stb = 0;
    endtask

    task automatic digit(input logic [3:0] d);
        strobe(d, 1, 0, 0, 0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!op_valid && n < 20) begin
            step();
            n++;
        end
        if (!op_valid) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic accept();
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    initial begin
        logic [10:0] held_value;
        reset_n = 0; digit_in = 0; digit_stb = 0; sign_stb = 0;
        enter_stb = 0; clear_stb = 0; out_ready = 0;
        step(); step();
        reset_n = 1;
        step();
        check("rst_valid", op_valid, 0);
        check("rst_value", op_value, 0);
        check("rst_index", op_index, 0);
        check("rst_busy", busy, 0);
        check("rst_disp", disp_digits, 0);
        check("rst_sign", disp_sign, 0);
        check("rst_err", err_digit, 0);

        // 1) 123, exact latency: valid seen high in the 5th cycle after the enter edge
        digit(1); digit(2); digit(3);
        check("t1_disp", disp_digits, 12'h123);
        strobe(0, 0, 0, 1, 0);
        check("t1_busy", busy, 1);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) step();
            check($sformatf("t1_lat_c%0d", c), op_valid, 0);
        end
        step();
        check("t1_lat_c5", op_valid, 1);
        check("t1_value", op_value, 11'd123);
        check("t1_index", op_index, 0);
        accept();
        check("t1_acc_valid", op_valid, 0);
        check("t1_acc_index", op_index, 1);
        check("t1_acc_disp", disp_digits, 0);
        check("t1_acc_busy", busy, 0);

        // 2) -999, last digit shares its cycle with the sign strobe
        digit(9); digit(9);
        strobe(9, 1, 1, 0, 0);
        check("t2_disp", disp_digits, 12'h999);
        check("t2_sign", disp_sign, 1);
        strobe(0, 0, 0, 1, 0);
        wait_valid("t2");
        check("t2_value", op_value, 11'h419);
        check("t2_index", op_index, 1);
        accept();
        check("t2_wrap_index", op_index, 0);
        check("t2_sign_clr", disp_sign, 0);

        // 3) invalid digit and overflowing digit
        digit(4'hA);
        check("t3_err_bad", err_digit, 1);
        check("t3_disp_bad", disp_digits, 0);
        step();
        check("t3_err_pulse", err_digit, 0);
        digit(1); digit(2); digit(3);
        check("t3_err_none", err_digit, 0);
        digit(4);
        check("t3_err_4th", err_digit, 1);
        check("t3_disp_4th", disp_digits, 12'h123);
        step();
        check("t3_err_4th_pulse", err_digit, 0);
        strobe(0, 0, 0, 0, 1);
        check("t3_clr_disp", disp_digits, 0);

        // 4) 507 held under back-pressure while strobes are ignored
        digit(5); digit(0); digit(7);
        strobe(0, 0, 0, 1, 0);
        wait_valid("t4");
        check("t4_value", op_value, 11'd507);
        held_value = op_value;
        for (int c = 0; c < 10; c++) begin
            strobe(4'((c % 3) + 1), (c % 3) == 0, (c % 3) == 1, (c % 3) == 2, 0);
            check($sformatf("t4_hold_valid%0d", c), op_valid, 1);
            check($sformatf("t4_hold_value%0d", c), op_value, held_value);
            check($sformatf("t4_hold_index%0d", c), op_index, 0);
            check($sformatf("t4_hold_err%0d", c), err_digit, 0);
        end
        check("t4_disp_kept", disp_digits, 12'h507);
        accept();
        check("t4_drop", op_valid, 0);
        check("t4_index", op_index, 1);

        // 5) negative zero, then clear during conversion
        strobe(0, 0, 1, 0, 0);
        strobe(0, 0, 0, 1, 0);
        wait_valid("t5");
        check("t5_negzero", op_value, 0);
        accept();
        check("t5_index", op_index, 0);
        digit(8); digit(1);
        strobe(0, 0, 0, 1, 0);
        step();
        strobe(0, 0, 0, 0, 1);
        check("t5_clr_busy", busy, 0);
        check("t5_clr_disp", disp_digits, 0);
        for (int c = 0; c < 8; c++) begin
            check($sformatf("t5_no_valid%0d", c), op_valid, 0);
            step();
        end
        check("t5_clr_index", op_index, 0);

        // 6) asynchronous reset in VALID, then a fresh entry
        digit(6);
        strobe(0, 0, 0, 1, 0);
        wait_valid("t6a");
        accept();
        digit(7);
        strobe(0, 0, 0, 1, 0);
        wait_valid("t6b");
        check("t6_pre_index", op_index, 1);
        check("t6_pre_value", op_value, 11'd7);
        reset_n = 0;
        #1;
        check("t6_rst_valid", op_valid, 0);
        check("t6_rst_value", op_value, 0);
        check("t6_rst_index", op_index, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_disp", disp_digits, 0);
        step();
        reset_n = 1;
        step();
        digit(0); digit(4); digit(2);
        check("t6_disp", disp_digits, 12'h042);
        strobe(0, 0, 0, 1, 0);
        wait_valid("t6c");
        check("t6_value", op_value, 11'd42);
        check("t6_index", op_index, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
